// File: rtl/xor_key_assembler_pkg.sv
// Shared types and constants for the XOR key assembler (package xor_pkg).
// Optional parity feature is selected with the XOR_KEY_PARITY_EN macro.
package xor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_READY  = 2'd2,
    ST_PARITY = 2'd3
  } state_t;

  localparam int DEFAULT_MSG_SIZE = 8;
  localparam int DEFAULT_CHUNK_W  = 4;

  // One extra bit so the count can hold NCHUNK itself.
  function automatic int chunkCntWidth(input int msgSize, input int chunkW);
    return $clog2(msgSize / chunkW) + 1;
  endfunction

endpackage

// File: rtl/xor_key_assembler_if.sv
// Handshake/bus bundle between the key source and the XOR key assembler.
// Used unchanged with or without XOR_KEY_PARITY_EN.
interface xor_key_assembler_if
  import xor_pkg::*;
#(
  parameter int MSG_SIZE = DEFAULT_MSG_SIZE,
  parameter int CHUNK_W  = DEFAULT_CHUNK_W
) ();

  localparam int CNT_W = chunkCntWidth(MSG_SIZE, CHUNK_W);

  logic                iEn;
  logic                iStart;
  logic [CHUNK_W-1:0]  iData;
  logic                iData_Valid;
  logic                iConsume;
  logic [MSG_SIZE-1:0] oKey_Assembled;
  logic                oKey_Valid;
  logic                oBusy;
  logic [CNT_W-1:0]    oChunk_Cnt;
  logic                oKey_Err;

  modport master (
    output iEn, iStart, iData, iData_Valid, iConsume,
    input  oKey_Assembled, oKey_Valid, oBusy, oChunk_Cnt, oKey_Err
  );

  modport slave (
    input  iEn, iStart, iData, iData_Valid, iConsume,
    output oKey_Assembled, oKey_Valid, oBusy, oChunk_Cnt, oKey_Err
  );

endinterface

// File: rtl/xor_key_assembler_shreg.sv
// Enable-gated CHUNK_W-step shift register with saturating chunk counter.
// Independent of XOR_KEY_PARITY_EN; the FSM in the top decides when to shift.
module xor_key_shreg
  import xor_pkg::*;
#(
  parameter int MSG_SIZE = DEFAULT_MSG_SIZE,
  parameter int CHUNK_W  = DEFAULT_CHUNK_W,
  parameter int CNT_W    = chunkCntWidth(MSG_SIZE, CHUNK_W)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_clear,
  input  logic                i_shift,
  input  logic [CHUNK_W-1:0]  i_data,
  output logic [MSG_SIZE-1:0] o_key,
  output logic [CNT_W-1:0]    o_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MSG_SIZE / CHUNK_W);

  logic [MSG_SIZE-1:0] r_key;
  logic [CNT_W-1:0]    r_cnt;
  logic [MSG_SIZE-1:0] w_nextKey;

  generate
    if (CHUNK_W == MSG_SIZE) begin : g_whole
      assign w_nextKey = i_data;
    end else begin : g_shift
      assign w_nextKey = {r_key[MSG_SIZE-CHUNK_W-1:0], i_data};
    end
  endgenerate

  // Clearing only resets the count; the old key stays visible until a new chunk lands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_shift) begin
        r_key <= w_nextKey;
        if (r_cnt != MAX_CNT) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_key = r_key;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/xor_key_assembler.sv
// Assembles a MSG_SIZE-bit key from CHUNK_W-bit beats and holds it until consumed.
// Define XOR_KEY_PARITY_EN to require a trailing even-parity beat before READY.
module xor_key_assembler
  import xor_pkg::*;
#(
  parameter int MSG_SIZE = DEFAULT_MSG_SIZE,
  parameter int CHUNK_W  = DEFAULT_CHUNK_W
) (
  input logic              iClk,
  input logic              iRst,
  xor_key_assembler_if.slave bus
);

  localparam int NCHUNK = MSG_SIZE / CHUNK_W;
  localparam int CNT_W  = chunkCntWidth(MSG_SIZE, CHUNK_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  state_t              r_state;
  logic                r_keyValid;
  logic                r_busy;
  logic                w_shift;
  logic                w_lastBeat;
  logic [MSG_SIZE-1:0] w_key;
  logic [CNT_W-1:0]    w_cnt;

  // iStart has priority, so a beat arriving with it never reaches the shifter.
  assign w_shift    = (r_state == ST_LOAD) && bus.iData_Valid && !bus.iStart;
  assign w_lastBeat = bus.iEn && w_shift && (w_cnt == LAST_CNT);

  xor_key_shreg #(
    .MSG_SIZE (MSG_SIZE),
    .CHUNK_W  (CHUNK_W),
    .CNT_W    (CNT_W)
  ) u_shreg (
    .i_clk   (iClk),
    .i_rst   (iRst),
    .i_en    (bus.iEn),
    .i_clear (bus.iStart),
    .i_shift (w_shift),
    .i_data  (bus.iData),
    .o_key   (w_key),
    .o_cnt   (w_cnt)
  );

`ifdef XOR_KEY_PARITY_EN
  logic r_keyErr;
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= ST_IDLE;
      r_keyValid <= 1'b0;
      r_busy     <= 1'b0;
`ifdef XOR_KEY_PARITY_EN
      r_keyErr   <= 1'b0;
`endif
    end else if (bus.iEn) begin
      if (bus.iStart) begin
        r_state    <= ST_LOAD;
        r_keyValid <= 1'b0;
        r_busy     <= 1'b1;
`ifdef XOR_KEY_PARITY_EN
        r_keyErr   <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (w_lastBeat) begin
`ifdef XOR_KEY_PARITY_EN
              r_state    <= ST_PARITY;
`else
              r_state    <= ST_READY;
              r_keyValid <= 1'b1;
              r_busy     <= 1'b0;
`endif
            end
          end
          ST_PARITY: begin
`ifdef XOR_KEY_PARITY_EN
            // The parity beat is judged against the fully assembled key.
            if (bus.iData_Valid) begin
              r_busy <= 1'b0;
              if (bus.iData[0] == ^w_key) begin
                r_state    <= ST_READY;
                r_keyValid <= 1'b1;
              end else begin
                r_state  <= ST_IDLE;
                r_keyErr <= 1'b1;
              end
            end
`else
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`endif
          end
          ST_READY: begin
            if (bus.iConsume) begin
              r_state    <= ST_IDLE;
              r_keyValid <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.oKey_Assembled = w_key;
  assign bus.oChunk_Cnt     = w_cnt;
  assign bus.oKey_Valid     = r_keyValid;
  assign bus.oBusy          = r_busy;
`ifdef XOR_KEY_PARITY_EN
  assign bus.oKey_Err       = r_keyErr;
`else
  assign bus.oKey_Err       = 1'b0;
`endif

endmodule

// File: tb/tb_xor_key_assembler.sv
// Self-checking bench for xor_key_assembler: directed scenarios plus a random run
// against a behavioural model; parity scenarios run when XOR_KEY_PARITY_EN is defined.
module tb_xor_key_assembler;
  import xor_pkg::*;

  localparam int MSG_SIZE = 8;
  localparam int CHUNK_W  = 4;
  localparam int NCHUNK   = MSG_SIZE / CHUNK_W;
  localparam int CNT_W    = chunkCntWidth(MSG_SIZE, CHUNK_W);

  logic iClk;
  logic iRst;
  int   nChecks;
  int   nErrors;

  xor_key_assembler_if #(.MSG_SIZE(MSG_SIZE), .CHUNK_W(CHUNK_W)) bus ();

  xor_key_assembler #(.MSG_SIZE(MSG_SIZE), .CHUNK_W(CHUNK_W)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Behavioural model: phase 0 idle, 1 collecting chunks, 2 key ready, 3 awaiting parity.
  logic [MSG_SIZE-1:0] mKey;
  int                  mCnt;
  int                  mPhase;
  bit                  mValid;
  bit                  mErr;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic quietInputs();
    bus.iEn = 1'b1; bus.iStart = 1'b0; bus.iData = '0;
    bus.iData_Valid = 1'b0; bus.iConsume = 1'b0;
  endtask

  task automatic doReset();
    iRst = 1'b1; tick(); iRst = 1'b0;
  endtask

  task automatic startLoad();
    bus.iStart = 1'b1; tick(); bus.iStart = 1'b0;
  endtask

  task automatic beat(input logic [CHUNK_W-1:0] d);
    bus.iData = d; bus.iData_Valid = 1'b1; tick(); bus.iData_Valid = 1'b0;
  endtask

  task automatic sendParity(input bit p);
`ifdef XOR_KEY_PARITY_EN
    beat(CHUNK_W'(p));
`endif
  endtask

  task automatic modelStep();
    if (iRst) begin
      mKey = '0; mCnt = 0; mPhase = 0; mValid = 0; mErr = 0;
    end else if (bus.iEn) begin
      if (bus.iStart) begin
        mPhase = 1; mCnt = 0; mValid = 0; mErr = 0;
      end else if (mPhase == 1 && bus.iData_Valid) begin
        mKey = (mKey << CHUNK_W) | MSG_SIZE'(bus.iData);
        mCnt = mCnt + 1;
        if (mCnt == NCHUNK) begin
`ifdef XOR_KEY_PARITY_EN
          mPhase = 3;
`else
          mPhase = 2; mValid = 1;
`endif
        end
      end else if (mPhase == 3 && bus.iData_Valid) begin
        if (bus.iData[0] == ^mKey) begin mPhase = 2; mValid = 1; end
        else begin mPhase = 0; mErr = 1; end
      end else if (mPhase == 2 && bus.iConsume) begin
        mPhase = 0; mValid = 0;
      end
    end
  endtask

  task automatic test_reset();
    bus.iEn = 1'b0; bus.iStart = 1'b1; bus.iData_Valid = 1'b1; bus.iData = 4'hF;
    doReset();
    quietInputs();
    nChecks++; if (bus.oKey_Assembled !== 8'h00) begin nErrors++; $display("[TB] FAIL reset_key: got %h expected 00", bus.oKey_Assembled); end
    nChecks++; if (bus.oKey_Valid !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.oKey_Valid); end
    nChecks++; if (bus.oBusy !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.oBusy); end
    nChecks++; if (bus.oChunk_Cnt !== 2'd0) begin nErrors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", bus.oChunk_Cnt); end
    nChecks++; if (bus.oKey_Err !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.oKey_Err); end
  endtask

  task automatic test_basic_load();
    startLoad();
    nChecks++; if (bus.oBusy !== 1'b1) begin nErrors++; $display("[TB] FAIL basic_busy_start: got %b expected 1", bus.oBusy); end
    nChecks++; if (bus.oChunk_Cnt !== 2'd0) begin nErrors++; $display("[TB] FAIL basic_cnt_start: got %0d expected 0", bus.oChunk_Cnt); end
    beat(4'hA);
    nChecks++; if (bus.oChunk_Cnt !== 2'd1) begin nErrors++; $display("[TB] FAIL basic_cnt_1: got %0d expected 1", bus.oChunk_Cnt); end
    nChecks++; if (bus.oKey_Valid !== 1'b0) begin nErrors++; $display("[TB] FAIL basic_valid_early: got %b expected 0", bus.oKey_Valid); end
    beat(4'h5);
    sendParity(1'b0);
    nChecks++; if (bus.oKey_Assembled !== 8'hA5) begin nErrors++; $display("[TB] FAIL basic_key: got %h expected a5", bus.oKey_Assembled); end
    nChecks++; if (bus.oKey_Valid !== 1'b1) begin nErrors++; $display("[TB] FAIL basic_valid: got %b expected 1", bus.oKey_Valid); end
    nChecks++; if (bus.oBusy !== 1'b0) begin nErrors++; $display("[TB] FAIL basic_busy_end: got %b expected 0", bus.oBusy); end
    nChecks++; if (bus.oChunk_Cnt !== 2'd2) begin nErrors++; $display("[TB] FAIL basic_cnt_2: got %0d expected 2", bus.oChunk_Cnt); end
  endtask

  task automatic test_gap_load();
    startLoad();
    nChecks++; if (bus.oKey_Valid !== 1'b0) begin nErrors++; $display("[TB] FAIL gap_valid_cleared: got %b expected 0", bus.oKey_Valid); end
    beat(4'hA);
    for (int i = 0; i < 2; i++) begin
      tick();
      nChecks++; if (bus.oBusy !== 1'b1 || bus.oChunk_Cnt !== 2'd1) begin nErrors++; $display("[TB] FAIL gap_hold: got busy=%b cnt=%0d expected busy=1 cnt=1", bus.oBusy, bus.oChunk_Cnt); end
    end
    beat(4'h5);
    sendParity(1'b0);
    nChecks++; if (bus.oKey_Assembled !== 8'hA5 || bus.oKey_Valid !== 1'b1) begin nErrors++; $display("[TB] FAIL gap_result: got key=%h valid=%b expected key=a5 valid=1", bus.oKey_Assembled, bus.oKey_Valid); end
  endtask

  task automatic test_ready_hold();
    beat(4'hF);
    nChecks++; if (bus.oKey_Assembled !== 8'hA5 || bus.oKey_Valid !== 1'b1 || bus.oChunk_Cnt !== 2'd2) begin nErrors++; $display("[TB] FAIL ready_ignore_data: got key=%h valid=%b cnt=%0d expected a5/1/2", bus.oKey_Assembled, bus.oKey_Valid, bus.oChunk_Cnt); end
    bus.iConsume = 1'b1; tick(); bus.iConsume = 1'b0;
    nChecks++; if (bus.oKey_Valid !== 1'b0) begin nErrors++; $display("[TB] FAIL consume_valid: got %b expected 0", bus.oKey_Valid); end
    nChecks++; if (bus.oKey_Assembled !== 8'hA5 || bus.oChunk_Cnt !== 2'd2) begin nErrors++; $display("[TB] FAIL consume_retain: got key=%h cnt=%0d expected a5/2", bus.oKey_Assembled, bus.oChunk_Cnt); end
    beat(4'h6);
    nChecks++; if (bus.oKey_Assembled !== 8'hA5 || bus.oBusy !== 1'b0) begin nErrors++; $display("[TB] FAIL idle_ignore_data: got key=%h busy=%b expected a5/0", bus.oKey_Assembled, bus.oBusy); end
  endtask

  task automatic test_reset_midload();
    startLoad();
    beat(4'h3);
    nChecks++; if (bus.oKey_Assembled !== 8'h53) begin nErrors++; $display("[TB] FAIL midload_key: got %h expected 53", bus.oKey_Assembled); end
    doReset();
    nChecks++; if (bus.oKey_Assembled !== 8'h00 || bus.oChunk_Cnt !== 2'd0 || bus.oBusy !== 1'b0 || bus.oKey_Valid !== 1'b0) begin nErrors++; $display("[TB] FAIL midload_reset: got key=%h cnt=%0d busy=%b valid=%b expected all 0", bus.oKey_Assembled, bus.oChunk_Cnt, bus.oBusy, bus.oKey_Valid); end
    beat(4'h9);
    nChecks++; if (bus.oKey_Assembled !== 8'h00 || bus.oChunk_Cnt !== 2'd0) begin nErrors++; $display("[TB] FAIL midload_no_start: got key=%h cnt=%0d expected 00/0", bus.oKey_Assembled, bus.oChunk_Cnt); end
  endtask

  task automatic test_restart();
    startLoad();
    beat(4'h7);
    bus.iStart = 1'b1; bus.iData_Valid = 1'b1; bus.iData = 4'hC;
    tick();
    bus.iStart = 1'b0; bus.iData_Valid = 1'b0;
    nChecks++; if (bus.oChunk_Cnt !== 2'd0 || bus.oKey_Assembled !== 8'h07 || bus.oBusy !== 1'b1) begin nErrors++; $display("[TB] FAIL restart_drop: got cnt=%0d key=%h busy=%b expected 0/07/1", bus.oChunk_Cnt, bus.oKey_Assembled, bus.oBusy); end
    beat(4'h1);
    beat(4'h2);
    sendParity(1'b0);
    nChecks++; if (bus.oKey_Assembled !== 8'h12 || bus.oKey_Valid !== 1'b1) begin nErrors++; $display("[TB] FAIL restart_key: got key=%h valid=%b expected 12/1", bus.oKey_Assembled, bus.oKey_Valid); end
  endtask

  task automatic test_enable_freeze();
    startLoad();
    beat(4'hA);
    for (int i = 0; i < 3; i++) begin
      bus.iEn = 1'b0; bus.iData_Valid = 1'b1; bus.iData = 4'h5;
      bus.iConsume = 1'b1; bus.iStart = (i == 1);
      tick();
      nChecks++; if (bus.oChunk_Cnt !== 2'd1 || bus.oKey_Assembled !== 8'h2A || bus.oBusy !== 1'b1 || bus.oKey_Valid !== 1'b0) begin nErrors++; $display("[TB] FAIL freeze_hold: got cnt=%0d key=%h busy=%b valid=%b expected 1/2a/1/0", bus.oChunk_Cnt, bus.oKey_Assembled, bus.oBusy, bus.oKey_Valid); end
    end
    quietInputs();
    beat(4'h5);
    sendParity(1'b0);
    nChecks++; if (bus.oKey_Assembled !== 8'hA5 || bus.oKey_Valid !== 1'b1) begin nErrors++; $display("[TB] FAIL freeze_resume: got key=%h valid=%b expected a5/1", bus.oKey_Assembled, bus.oKey_Valid); end
  endtask

`ifdef XOR_KEY_PARITY_EN
  task automatic test_parity();
    startLoad();
    beat(4'hA);
    beat(4'h5);
    nChecks++; if (bus.oBusy !== 1'b1 || bus.oKey_Valid !== 1'b0 || bus.oChunk_Cnt !== 2'd2) begin nErrors++; $display("[TB] FAIL parity_wait: got busy=%b valid=%b cnt=%0d expected 1/0/2", bus.oBusy, bus.oKey_Valid, bus.oChunk_Cnt); end
    beat(4'h1);
    nChecks++; if (bus.oKey_Err !== 1'b1 || bus.oKey_Valid !== 1'b0 || bus.oBusy !== 1'b0) begin nErrors++; $display("[TB] FAIL parity_bad: got err=%b valid=%b busy=%b expected 1/0/0", bus.oKey_Err, bus.oKey_Valid, bus.oBusy); end
    nChecks++; if (bus.oKey_Assembled !== 8'hA5 || bus.oChunk_Cnt !== 2'd2) begin nErrors++; $display("[TB] FAIL parity_no_shift: got key=%h cnt=%0d expected a5/2", bus.oKey_Assembled, bus.oChunk_Cnt); end
    startLoad();
    nChecks++; if (bus.oKey_Err !== 1'b0) begin nErrors++; $display("[TB] FAIL parity_err_clear: got %b expected 0", bus.oKey_Err); end
    beat(4'hA);
    beat(4'h5);
    beat(4'hE);
    nChecks++; if (bus.oKey_Valid !== 1'b1 || bus.oKey_Err !== 1'b0) begin nErrors++; $display("[TB] FAIL parity_good: got valid=%b err=%b expected 1/0", bus.oKey_Valid, bus.oKey_Err); end
  endtask
`endif

  task automatic test_random();
    quietInputs();
    doReset();
    mKey = '0; mCnt = 0; mPhase = 0; mValid = 0; mErr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      iRst            = ($urandom_range(0, 59) == 0);
      bus.iEn         = ($urandom_range(0, 7) != 0);
      bus.iStart      = ($urandom_range(0, 11) == 0);
      bus.iData_Valid = $urandom_range(0, 1) == 1;
      bus.iData       = CHUNK_W'($urandom);
      bus.iConsume    = ($urandom_range(0, 3) == 0);
      modelStep();
      tick();
      nChecks++;
      if (bus.oKey_Assembled !== mKey || bus.oKey_Valid !== mValid || bus.oChunk_Cnt !== CNT_W'(mCnt) ||
          bus.oBusy !== (mPhase == 1 || mPhase == 3) || bus.oKey_Err !== mErr) begin
        nErrors++;
        $display("[TB] FAIL random_cycle_%0d: got key=%h valid=%b cnt=%0d busy=%b err=%b expected key=%h valid=%b cnt=%0d busy=%b err=%b",
                 cyc, bus.oKey_Assembled, bus.oKey_Valid, bus.oChunk_Cnt, bus.oBusy, bus.oKey_Err,
                 mKey, mValid, mCnt, (mPhase == 1 || mPhase == 3), mErr);
      end
    end
    iRst = 1'b0;
    quietInputs();
  endtask

  initial begin
    nChecks = 0;
    nErrors = 0;
    iRst = 1'b0;
    quietInputs();
    tick();
    test_reset();
    test_basic_load();
    test_gap_load();
    test_ready_hold();
    test_reset_midload();
    test_restart();
    test_enable_freeze();
`ifdef XOR_KEY_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/xor_key_assembler.md
Name: xor_key_assembler

Overview:
Upstream stage of the XOR encrypt block. Receives the key serially in CHUNK_W-bit beats from narrow input pins and assembles a MSG_SIZE-bit key. Presents the key with a valid flag and holds it stable until the encrypt stage consumes it. Its output drives the encrypt block's assembled-key input directly.

Parameters:
MSG_SIZE, 8, key width in bits; must be an integer multiple of CHUNK_W.
CHUNK_W, 4, bits accepted per input beat; 1 <= CHUNK_W <= MSG_SIZE.

Ports:
iClk  input  1  single clock, rising edge.
iRst  input  1  synchronous, active-high reset.
iEn  input  1  global enable; when low, all state and outputs freeze (reset still wins).
iStart  input  1  begin a new key load; restarts from any state.
iData  input  CHUNK_W  key chunk, MSB chunk first.
iData_Valid  input  1  iData is valid this cycle.
iConsume  input  1  downstream has taken the key.
oKey_Assembled  output  MSG_SIZE  assembled key.
oKey_Valid  output  1  key complete and stable.
oBusy  output  1  load in progress (LOAD or PARITY state).
oChunk_Cnt  output  clog2(MSG_SIZE/CHUNK_W)+1  number of chunks accepted in the current load.
oKey_Err  output  1  parity failure, sticky until next iStart or reset.

Behaviour:
- All outputs registered. Reset is synchronous and active-high: iRst=1 at a rising edge gives state=IDLE, oKey_Assembled=0, oKey_Valid=0, oBusy=0, oChunk_Cnt=0, oKey_Err=0. Reset takes priority over iEn and all other inputs.
- iEn=0: nothing updates; iStart, iData_Valid and iConsume are ignored that cycle.
- Let NCHUNK = MSG_SIZE/CHUNK_W.
- FSM states: IDLE, LOAD, PARITY (present only with the optional feature), READY.
- iStart in any state:
  - Go to LOAD, set oChunk_Cnt=0, oKey_Valid=0, oKey_Err=0.
  - Keep oKey_Assembled unchanged until the first chunk arrives.
  - iStart wins over a simultaneous iData_Valid or iConsume; that data beat is dropped.
- LOAD:
  - Each cycle with iData_Valid=1: oKey_Assembled <= {oKey_Assembled[MSG_SIZE-CHUNK_W-1:0], iData} and oChunk_Cnt increments.
  - On the beat where the count reaches NCHUNK, go to READY (or PARITY).
  - Latency: oKey_Valid=1 in the cycle after the edge that captures the last chunk.
  - Gaps with iData_Valid=0 are allowed and hold state.
- READY:
  - oKey_Valid=1, key held stable, iData_Valid ignored.
  - iConsume=1 gives IDLE and oKey_Valid=0. oKey_Assembled is retained, so the downstream register may sample late.
- IDLE: iData_Valid and iConsume are ignored.
- oBusy=1 exactly when state is LOAD or PARITY.
- oChunk_Cnt saturates at NCHUNK and never wraps. It holds its value in READY and IDLE until the next iStart.
- Reset mid-load aborts the load and clears everything; no partial key is flagged valid.

Optional Feature:
Macro XOR_KEY_PARITY_EN.
- Defined:
  - After the last key chunk, the FSM enters PARITY and waits for one more iData_Valid beat.
  - iData[0] must equal the even parity (XOR reduction) of oKey_Assembled.
  - Match: go to READY.
  - Mismatch: set oKey_Err=1, go to IDLE, oKey_Valid stays 0.
  - The parity beat does not shift the key or increment oChunk_Cnt.
- Undefined: no PARITY state; oKey_Err is tied to 0.

Decomposition:
- Shared package xor_pkg holds:
  - the FSM state typedef (2-bit encoding: IDLE=0, LOAD=1, READY=2, PARITY=3);
  - default MSG_SIZE/CHUNK_W constants;
  - the chunk-count width function.
- One natural sub-module: xor_key_shreg, the enable-gated CHUNK_W-step shift register with load counter. The FSM stays in the top module.

Test Plan:
- MSG_SIZE=8, CHUNK_W=4. iStart, then beats 0xA, 0x5 on consecutive cycles → oKey_Assembled=0xA5 and oKey_Valid=1 one cycle after the 0x5 edge. oBusy falls the same cycle. oChunk_Cnt=2.
- Same load with two idle cycles between the beats → identical result, delayed by 2 cycles. oBusy stays high during the gap.
- READY with key 0xA5: drive iData_Valid=1, iData=0xF → key unchanged. Then iConsume=1 → oKey_Valid=0 next cycle, oKey_Assembled still 0xA5.
- After beat 0x3, assert iRst for one cycle → all outputs 0, state IDLE. A following beat with no iStart is ignored.
- iStart asserted together with iData_Valid (iData=0xC) mid-load → count resets to 0 and the 0xC beat is dropped. Beats 0x1, 0x2 → key 0x12.
- With XOR_KEY_PARITY_EN, key 0xA5 (parity 0): parity beat iData[0]=0 → oKey_Valid=1. Repeat with iData[0]=1 → oKey_Err=1, oKey_Valid=0, state IDLE. iEn=0 for 3 cycles mid-load → no state change.
